// File: rtl/mpu_pkg.sv
// Shared processor-memory constants and the arbiter lock FSM encoding.
// Also used by the datapath for the memory geometry defaults.
package mpu_pkg;

   localparam int unsigned MPU_ADDR_W   = 5;
   localparam int unsigned MPU_DATA_W   = 8;
   localparam int unsigned ARB_MAX_WAIT = 3;

   typedef enum logic [1:0] {
      UNLOCKED  = 2'd0,
      LOCK_PEND = 2'd1,
      LOCKED    = 2'd2
   } lock_state_e;

   // Counter width able to hold 0..max_val inclusive, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating host-wait counter: counts lost arbitration cycles, clears on demand,
// and flags 'expired' once the count reaches MAX_WAIT.
module arb_wait_counter
   import mpu_pkg::*;
#(
   parameter int unsigned MAX_WAIT = ARB_MAX_WAIT
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic expired_o
);

   localparam int unsigned     CNT_W = cnt_width(MAX_WAIT);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between CPU datapath and host port, with anti-starvation
// for the host and a host lock that stalls the CPU during burst program loading.
module mem_arbiter
   import mpu_pkg::*;
#(
   parameter int unsigned ADDR_W   = MPU_ADDR_W,
   parameter int unsigned DATA_W   = MPU_DATA_W,
   parameter int unsigned MAX_WAIT = ARB_MAX_WAIT
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,

   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,

   input  logic              lock_req,
   output logic              lock_ack,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   lock_state_e state_q;
   logic        lock_ack_q;
   logic        cpu_rv_q;
   logic        host_rv_q;
   logic        host_expired;
   logic        locked;

   assign locked = (state_q == LOCKED);

   // Host wins when locked, when its wait has expired, or when the CPU is idle.
   always_comb begin
      cpu_gnt  = 1'b0;
      host_gnt = 1'b0;
      if (!reset) begin
         if (locked) begin
            host_gnt = host_req;
         end else if (host_req && (host_expired || !cpu_req)) begin
            host_gnt = 1'b1;
         end else begin
            cpu_gnt = cpu_req;
         end
      end
   end

   always_comb begin
      mem_en    = cpu_gnt | host_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (host_gnt) begin
         mem_we    = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end else if (cpu_gnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
   end

   assign cpu_stall = cpu_req & ~cpu_gnt;

   arb_wait_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_cnt (
      .clk_i     (clk),
      .reset_i   (reset),
      .inc_i     (host_req & ~host_gnt),
      .clr_i     (host_gnt | ~host_req),
      .expired_o (host_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_rv_q  <= 1'b0;
         host_rv_q <= 1'b0;
      end else begin
         cpu_rv_q  <= cpu_gnt & ~cpu_we;
         host_rv_q <= host_gnt & ~host_we;
      end
   end

   // Lock is taken only when the CPU sits at an access boundary: no read data
   // returning this cycle and no request that could be granted this cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= UNLOCKED;
         lock_ack_q <= 1'b0;
      end else begin
         case (state_q)
            UNLOCKED: begin
               if (lock_req) begin
                  state_q <= LOCK_PEND;
               end
            end
            LOCK_PEND: begin
               if (!lock_req) begin
                  state_q <= UNLOCKED;
               end else if (!cpu_rv_q && !cpu_req) begin
                  state_q    <= LOCKED;
                  lock_ack_q <= 1'b1;
               end
            end
            LOCKED: begin
               if (!lock_req) begin
                  state_q    <= UNLOCKED;
                  lock_ack_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= UNLOCKED;
               lock_ack_q <= 1'b0;
            end
         endcase
      end
   end

   assign lock_ack = lock_ack_q;

   // Read data bypasses straight from memory; rvalid is masked so a read in
   // flight across a reset never reports completion.
   assign cpu_rvalid  = cpu_rv_q & ~reset;
   assign host_rvalid = host_rv_q & ~reset;
   assign cpu_rdata   = mem_rdata;
   assign host_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a rule-level reference model.
module tb_mem_arbiter;
   import mpu_pkg::*;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 8;
   localparam int unsigned MW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          host_req, host_we, host_gnt, host_rvalid;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata, host_rdata;
   logic          lock_req, lock_ack;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .lock_req(lock_req), .lock_ack(lock_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Synchronous single-port memory with one-cycle read latency.
   logic [DW-1:0] mem [32];
   logic [DW-1:0] mem_rd_q;
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rd_q <= mem[mem_addr];
      end
   end
   assign mem_rdata = mem_rd_q;

   // Reference model state
   logic [DW-1:0] shadow [32];
   int            host_wait;
   bit            lk_pend, lk_on;
   bit            m_cpu_rv, m_host_rv;
   logic [DW-1:0] m_cpu_data, m_host_data;
   int            cpu_grants, host_grants;
   int            n_checks = 0;
   int            n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Check one cycle at the falling edge, advance the model, return just after the rising edge.
   task automatic tick();
      bit eh, ec, rv_now;
      @(negedge clk);
      if (reset) begin
         eh = 0; ec = 0;
      end else if (lk_on) begin
         eh = host_req; ec = 0;
      end else begin
         eh = host_req && ((host_wait >= MW) || !cpu_req);
         ec = cpu_req && !eh;
      end
      chk("cpu_gnt",     cpu_gnt,     ec);
      chk("host_gnt",    host_gnt,    eh);
      chk("mem_en",      mem_en,      ec | eh);
      chk("cpu_stall",   cpu_stall,   cpu_req && !ec);
      chk("lock_ack",    lock_ack,    lk_on);
      chk("cpu_rvalid",  cpu_rvalid,  !reset && m_cpu_rv);
      chk("host_rvalid", host_rvalid, !reset && m_host_rv);
      if (!reset && m_cpu_rv)  chk("cpu_rdata",  cpu_rdata,  m_cpu_data);
      if (!reset && m_host_rv) chk("host_rdata", host_rdata, m_host_data);
      if (eh) begin
         chk("mem_we_h",    mem_we,    host_we);
         chk("mem_addr_h",  mem_addr,  host_addr);
         chk("mem_wdata_h", mem_wdata, host_wdata);
      end else if (ec) begin
         chk("mem_we_c",    mem_we,    cpu_we);
         chk("mem_addr_c",  mem_addr,  cpu_addr);
         chk("mem_wdata_c", mem_wdata, cpu_wdata);
      end else if (reset) begin
         chk("mem_we_rst",    mem_we,    0);
         chk("mem_addr_rst",  mem_addr,  0);
         chk("mem_wdata_rst", mem_wdata, 0);
      end
      if (ec) cpu_grants++;
      if (eh) host_grants++;

      rv_now = m_cpu_rv;
      if (reset) begin
         host_wait = 0; m_cpu_rv = 0; m_host_rv = 0; lk_pend = 0; lk_on = 0;
      end else begin
         host_wait = (host_req && !eh) ? ((host_wait < MW) ? host_wait + 1 : MW) : 0;
         m_cpu_rv  = ec && !cpu_we;
         m_host_rv = eh && !host_we;
         if (ec) begin
            if (cpu_we) shadow[cpu_addr] = cpu_wdata;
            else        m_cpu_data = shadow[cpu_addr];
         end
         if (eh) begin
            if (host_we) shadow[host_addr] = host_wdata;
            else         m_host_data = shadow[host_addr];
         end
         if (lk_on) begin
            if (!lock_req) lk_on = 0;
         end else if (lk_pend) begin
            if (!lock_req) lk_pend = 0;
            else if (!rv_now && !cpu_req) begin
               lk_pend = 0; lk_on = 1;
            end
         end else if (lock_req) begin
            lk_pend = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_lock(input string tag);
      int k = 0;
      while (lock_ack !== 1'b1 && k < 10) begin
         tick();
         k++;
      end
      chk(tag, lock_ack, 1);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem[i]    = DW'($urandom);
         shadow[i] = mem[i];
      end
      mem[3]    = 8'hA7;
      shadow[3] = 8'hA7;
      host_wait = 0; lk_pend = 0; lk_on = 0; m_cpu_rv = 0; m_host_rv = 0;
      m_cpu_data = '0; m_host_data = '0;

      // Reset with both requesters active
      reset = 1; lock_req = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'h01; cpu_wdata = 8'h00;
      host_req = 1; host_we = 0; host_addr = 5'h02; host_wdata = 8'h00;
      tick(); tick();
      reset = 0; host_req = 0;
      cpu_grants = 0;
      tick();
      chk("t1_first_cpu", cpu_grants, 1);

      // CPU read of a known word
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'h03;
      tick();
      cpu_req = 0;
      tick();

      // Continuous contention: three CPU grants per host grant
      cpu_grants = 0; host_grants = 0;
      cpu_req = 1; host_req = 1;
      for (int i = 0; i < 12; i++) begin
         cpu_addr = AW'($urandom); host_addr = AW'($urandom);
         tick();
      end
      chk("t3_host_share", host_grants, 3);
      chk("t3_cpu_share",  cpu_grants,  9);

      // Host write while CPU idle, then CPU readback
      cpu_req = 0;
      host_req = 1; host_we = 1; host_addr = 5'h1F; host_wdata = 8'h5C;
      tick();
      host_req = 0; host_we = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'h1F;
      tick();
      cpu_req = 0;
      tick();
      chk("t4_readback_mem", mem[31], 8'h5C);

      // Lock requested during a CPU read, then host burst load
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'h1F; lock_req = 1;
      tick();
      cpu_req = 0;
      wait_lock("t5_lock_reached");
      cpu_req = 1; cpu_we = 1; cpu_wdata = 8'hEE;
      cpu_grants = 0; host_grants = 0;
      host_req = 1; host_we = 1;
      for (int i = 0; i < 32; i++) begin
         host_addr = AW'(i); host_wdata = DW'($urandom);
         tick();
      end
      chk("t5_burst_host", host_grants, 32);
      chk("t5_burst_cpu",  cpu_grants,  0);
      lock_req = 0; host_req = 0;
      tick();
      cpu_we = 0; cpu_grants = 0;
      tick();
      chk("t5_cpu_after_unlock", cpu_grants, 1);
      cpu_req = 0;
      tick();

      // Reset pulse while locked with a host read in flight
      lock_req = 1;
      wait_lock("t6_lock_reached");
      host_req = 1; host_we = 0; host_addr = 5'h05;
      tick();
      host_req = 0; reset = 1; lock_req = 0;
      tick();
      reset = 0;
      cpu_req = 1; host_req = 1;
      cpu_grants = 0; host_grants = 0;
      for (int i = 0; i < 8; i++) tick();
      chk("t6_host_share_after_reset", host_grants, 2);

      // Random traffic
      cpu_req = 0; host_req = 0;
      for (int i = 0; i < 600; i++) begin
         cpu_req    = ($urandom_range(3) != 0);
         cpu_we     = $urandom_range(1);
         cpu_addr   = AW'($urandom);
         cpu_wdata  = DW'($urandom);
         host_req   = ($urandom_range(2) == 0);
         host_we    = $urandom_range(1);
         host_addr  = AW'($urandom);
         host_wdata = DW'($urandom);
         if ($urandom_range(19) == 0) lock_req = ~lock_req;
         reset = ($urandom_range(99) == 0);
         tick();
      end
      reset = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
